// File: rtl/din_syn_rx_pkg.sv
// Shared constants and FSM encoding for the DIN/CLK/SYNC serial link receiver.
// DS_N_BITS is the one place the frame length is defined for both ends of the link.
package din_syn_rx_pkg;

  localparam int DS_N_BITS      = 491;
  localparam int DS_SYNC_STAGES = 2;
  localparam int DS_CNT_W       = 9;

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
    DS_SHIFT = 2'd1,
    DS_DONE  = 2'd2
  } ds_state_t;

endpackage

// File: rtl/ds_sync_edge.sv
// Pin synchroniser plus history flop; level/rise/fall are valid SYNC_STAGES cycles after the pin moves.
// Free-running, no flow control.
module ds_sync_edge
  import din_syn_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DS_SYNC_STAGES
) (
  input  logic clk_in,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/din_syn_rx.sv
// Deserialises one frame per SYNC window from the DIN/CLK/SYNC pins into rx_data.
// rx_valid fires SYNC_STAGES+2 clk_in cycles after the SYNC pin falls; no backpressure, results hold until the next frame.
module din_syn_rx
  import din_syn_rx_pkg::*;
#(
  parameter int N_BITS      = DS_N_BITS,
  parameter int SYNC_STAGES = DS_SYNC_STAGES,
  parameter int CNT_W       = DS_CNT_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              ser_clk,
  input  logic              ser_din,
  input  logic              ser_syn,
  output logic [N_BITS-1:0] rx_data,
  output logic [CNT_W-1:0]  rx_bit_cnt,
  output logic              rx_len_err,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic [7:0]        frame_cnt
);

  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(N_BITS);

  logic clk_lvl, clk_rise, clk_fall;
  logic din_s, din_rise, din_fall;
  logic syn_lvl, syn_rise, syn_fall;
  logic unused_edges;

  ds_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk (
    .clk_in(clk_in), .rst(rst), .pin(ser_clk),
    .level(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );

  ds_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_din (
    .clk_in(clk_in), .rst(rst), .pin(ser_din),
    .level(din_s), .rise(din_rise), .fall(din_fall)
  );

  ds_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_syn (
    .clk_in(clk_in), .rst(rst), .pin(ser_syn),
    .level(syn_lvl), .rise(syn_rise), .fall(syn_fall)
  );

  assign unused_edges = ^{clk_lvl, clk_fall, din_rise, din_fall, syn_lvl};

  ds_state_t         state, state_nxt;
  logic [N_BITS-1:0] sr;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= DS_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_busy   = 1'b0;
    case (state)
      DS_IDLE:  if (syn_rise) state_nxt = DS_SHIFT;
      DS_SHIFT: begin
        rx_busy = 1'b1;
        if (syn_fall) state_nxt = DS_DONE;
      end
      DS_DONE:  state_nxt = DS_IDLE;
      default:  state_nxt = DS_IDLE;
    endcase
  end

  // A clock edge coinciding with the SYNC rise is the first bit of the frame.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        DS_IDLE: begin
          if (syn_rise) begin
            sr  <= {{(N_BITS-1){1'b0}}, din_s & clk_rise};
            cnt <= {{(CNT_W-1){1'b0}}, clk_rise};
            ovf <= 1'b0;
          end
        end
        DS_SHIFT: begin
          if (clk_rise) begin
            sr <= {sr[N_BITS-2:0], din_s};
            if (cnt == N_MAX) ovf <= 1'b1;
            else              cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_bit_cnt <= '0;
      rx_len_err <= 1'b0;
      rx_valid   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      rx_valid <= (state == DS_DONE);
      if (state == DS_DONE) begin
        rx_data    <= sr;
        rx_bit_cnt <= cnt;
        rx_len_err <= (cnt != N_MAX) | ovf;
        frame_cnt  <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
